signed_frame_acc: RTL and testbench
===================================

Name: signed_frame_acc

Overview:
- Downstream consumer of the 4-bit signed sample stream produced by test_signed (sample bus `dout`, valid `dout_flag`).
- Groups every N_SAMPLES valid samples into a frame and reports that frame's signed sum, maximum and minimum.
- Results are reported as a one-cycle result strobe.
- Feeds status/debug logic and any later DSP stage.

Parameters:
- DIN_W, 4, sample width in bits (two's complement).
- N_SAMPLES, 8, samples per frame; must be at least 2.
- SUM_W, DIN_W+clog2(N_SAMPLES) (7 by default), width of the sum; derived, never overridden. Overflow is impossible by construction.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- din  in  DIN_W  signed sample; connects to upstream `dout`.
- din_flag  in  1  sample valid, one cycle per sample; connects to upstream `dout_flag`.
- clr  in  1  synchronous abort of the partial frame.
- sum_out  out  SUM_W  signed frame sum; held until the next result.
- max_out  out  DIN_W  signed frame maximum; held.
- min_out  out  DIN_W  signed frame minimum; held.
- sum_flag  out  1  one-cycle pulse; marks sum_out, max_out and min_out as newly valid.
- busy  out  1  high while a frame is partially collected (sample count not 0).

Behaviour:
- Reset: clk and rst ports as in the codebase. rst is asynchronous and active-high. While rst is high:
  - sum_out, max_out, min_out = 0
  - sum_flag = 0, busy = 0
  - internal accumulator, running max/min and sample counter (cnt) = 0
- Sign handling: din is sign-extended to SUM_W before it is added. All compares are signed.
- On each cycle with din_flag=1 and clr=0, the sample is counted:
  - If cnt==0 (first sample of a frame): acc <= sext(din); rmax <= din; rmin <= din.
  - Otherwise: acc <= acc+sext(din); rmax <= signed max(rmax,din); rmin <= signed min(rmin,din).
  - If cnt < N_SAMPLES-1: cnt <= cnt+1.
- Last sample of a frame (cnt==N_SAMPLES-1 and din_flag=1):
  - Results include this sample: sum_out <= acc+sext(din); max_out/min_out <= the updated max/min.
  - sum_flag = 1 in the next cycle, for exactly one cycle.
  - cnt <= 0.
  - Latency: one clock from the last sample's edge to sum_flag.
- Back-to-back frames:
  - A sample arriving in the cycle sum_flag is high is the first sample of the new frame.
  - There is no dead cycle between frames.
- Gaps: din_flag low cycles are ignored. Frame state holds indefinitely.
- clr:
  - With din_flag=0: cnt <= 0. The partial frame is discarded, outputs are unchanged, and no sum_flag is produced.
  - With din_flag=1: the partial frame is discarded and din becomes sample 1 of a new frame (cnt <= 1).
  - On the last-sample cycle, clr has priority: no result is emitted.
- busy = (cnt != 0), registered.
- Reset mid-frame: the partial frame is lost and the next valid sample starts a fresh frame.
- Held outputs change only together with a sum_flag pulse (or with reset).

Decomposition:
- Package signed_frame_pkg holds:
  - DIN_W default and N_SAMPLES default
  - a constant-function clog2
  - the SUM_W derivation
  - a sign-extend function
- One sub-module: signed_minmax. It is a registered running max/min tracker with inputs load, update and sample, and outputs max and min. It is instantiated once.
- Counter and accumulator stay in the top.

Test Plan:
1. Reset: hold rst high for 50 ns while driving din_flag with random din -> sum_out, max_out, min_out, sum_flag and busy all remain 0.
2. Eight consecutive samples of +7 (4'b0111) -> one cycle after the 8th sample: sum_flag=1 for one cycle, sum_out=56 (7'b0111000), max_out=min_out=+7.
3. Eight samples of -8 (4'b1000), with 2-cycle gaps -> sum_out=-64 (7'b1000000), max_out=min_out=-8, busy low after the result.
4. Samples +1,-1,+2,-2,+3,-3,+7,-8 -> sum_out=-1 (7'b1111111), max_out=+7, min_out=-8.
5. din_flag held high for 16 cycles with din=+1, then din=-1 -> sum_flag pulses exactly 8 cycles apart. Results: frame 1 sum=+8, frame 2 sum=-8, max=min=-1 for frame 2.
6. Three samples of +5, then clr, then eight samples of +1 -> no result after the clr, then sum_out=8.
   - Same stimulus but with an async rst pulse after three samples -> same sum_out=8 and busy=0 during reset.

Source files
------------

// File: rtl/signed_frame_pkg.sv
// Shared widths and helpers for the signed frame accumulator: defaults, a
// constant clog2, the sum-width rule and a generic sign extension.
package signed_frame_pkg;

  localparam int DIN_W_DEF     = 4;
  localparam int N_SAMPLES_DEF = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // N samples of DIN_W bits can never overflow DIN_W + clog2(N) bits.
  function automatic int sum_width(input int din_w, input int n_samples);
    return din_w + clog2(n_samples);
  endfunction

  // Replicates bit (width-1) of value into every higher bit of the 32-bit result.
  function automatic logic [31:0] sext(input logic [31:0] value, input int width);
    return 32'($signed(value << (32 - width)) >>> (32 - width));
  endfunction

endpackage

// File: rtl/signed_minmax.sv
// Registered running signed max/min tracker: load restarts both trackers
// from one sample, update folds a further sample into them.
module signed_minmax
  import signed_frame_pkg::*;
#(
  parameter int W = DIN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                update,
  input  logic signed [W-1:0] sample,
  output logic signed [W-1:0] max,
  output logic signed [W-1:0] min
);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max <= '0;
      min <= '0;
    end else if (load) begin
      max <= sample;
      min <= sample;
    end else if (update) begin
      if (sample > max) max <= sample;
      if (sample < min) min <= sample;
    end
  end

endmodule

// File: rtl/signed_frame_acc.sv
// Groups every N_SAMPLES valid signed samples into a frame and reports the
// frame's sum, maximum and minimum with a one-cycle result strobe.
module signed_frame_acc
  import signed_frame_pkg::*;
#(
  parameter  int DIN_W     = DIN_W_DEF,
  parameter  int N_SAMPLES = N_SAMPLES_DEF,
  localparam int SUM_W     = sum_width(DIN_W, N_SAMPLES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [DIN_W-1:0] din,
  input  logic                    din_flag,
  input  logic                    clr,
  output logic signed [SUM_W-1:0] sum_out,
  output logic signed [DIN_W-1:0] max_out,
  output logic signed [DIN_W-1:0] min_out,
  output logic                    sum_flag,
  output logic                    busy
);

  localparam int              CNT_W    = clog2(N_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

  logic [CNT_W-1:0]        cnt, cnt_next;
  logic signed [SUM_W-1:0] acc, acc_next, din_ext;
  logic signed [DIN_W-1:0] rmax, rmin, max_next, min_next;
  logic                    start, last;

  assign din_ext = SUM_W'(sext(32'(unsigned'(din)), DIN_W));

  // A clr accompanied by a sample restarts the frame with that sample.
  assign start = din_flag && (clr || cnt == '0);
  assign last  = din_flag && !clr && cnt == LAST_CNT;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    cnt_next = cnt;
    if (clr)           cnt_next = din_flag ? CNT_W'(1) : '0;
    else if (din_flag) cnt_next = last ? '0 : cnt + 1'b1;
    acc_next = start ? din_ext : acc + din_ext;
    max_next = (din > rmax) ? din : rmax;
    min_next = (din < rmin) ? din : rmin;
  end

  signed_minmax #(.W(DIN_W)) u_minmax (
    .clk    (clk),
    .rst    (rst),
    .load   (start),
    .update (din_flag && !start),
    .sample (din),
    .max    (rmax),
    .min    (rmin)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      sum_flag <= 1'b0;
      sum_out  <= '0;
      max_out  <= '0;
      min_out  <= '0;
    end else begin
      cnt      <= cnt_next;
      busy     <= (cnt_next != '0);
      sum_flag <= last;
      if (din_flag) acc <= acc_next;
      if (last) begin
        sum_out <= acc_next;
        max_out <= max_next;
        min_out <= min_next;
      end
    end
  end

endmodule

// File: tb/tb_signed_frame_acc.sv
// Self-checking bench for signed_frame_acc against a frame-level reference
// model kept as a queue of the samples collected so far.
module tb_signed_frame_acc;

  localparam int N = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [3:0] din;
  logic              din_flag;
  logic              clr;
  logic signed [6:0] sum_out;
  logic signed [3:0] max_out;
  logic signed [3:0] min_out;
  logic              sum_flag;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  int frame[$];
  int e_sum, e_max, e_min;
  bit e_flag;

  signed_frame_acc dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_flag (din_flag),
    .clr      (clr),
    .sum_out  (sum_out),
    .max_out  (max_out),
    .min_out  (min_out),
    .sum_flag (sum_flag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_flag"}, 32'(sum_flag), 32'(e_flag));
    check({tag, "_busy"}, 32'(busy), 32'(frame.size() != 0));
    check({tag, "_sum"},  32'(sum_out), e_sum);
    check({tag, "_max"},  32'(max_out), e_max);
    check({tag, "_min"},  32'(min_out), e_min);
  endtask

  task automatic model_reset();
    frame.delete();
    e_sum  = 0;
    e_max  = 0;
    e_min  = 0;
    e_flag = 0;
  endtask

  // One clock: drive inputs at the falling edge, update the model, check after the rising edge.
  task automatic step(input string tag, input bit f, input int d, input bit c);
    @(negedge clk);
    din_flag = f;
    din      = 4'(d);
    clr      = c;
    e_flag   = 0;
    if (c) frame.delete();
    if (f) begin
      frame.push_back(d);
      if (frame.size() == N) begin
        e_sum = 0;
        e_max = frame[0];
        e_min = frame[0];
        foreach (frame[i]) begin
          e_sum += frame[i];
          if (frame[i] > e_max) e_max = frame[i];
          if (frame[i] < e_min) e_min = frame[i];
        end
        e_flag = 1;
        frame.delete();
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    int t4[8] = '{1, -1, 2, -2, 3, -3, 7, -8};
    int last_flag_cycle;
    int cycle;

    rst = 1'b1; din = '0; din_flag = 1'b0; clr = 1'b0;
    model_reset();

    // Reset held for 50 ns with random samples presented.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      din_flag = 1'($urandom_range(0, 1));
      din      = 4'($urandom_range(0, 15));
      @(posedge clk);
      #1;
      check_all("reset");
    end
    @(negedge clk);
    rst = 1'b0; din_flag = 1'b0;

    // Eight consecutive +7.
    for (int i = 0; i < N; i++) step("t2", 1, 7, 0);
    check("t2_sum_lit", 32'(sum_out), 56);
    step("t2_after", 0, 0, 0);

    // Eight -8 with two-cycle gaps.
    for (int i = 0; i < N; i++) begin
      step("t3", 1, -8, 0);
      if (i != N - 1) begin
        step("t3_gap", 0, 3, 0);
        step("t3_gap", 0, 5, 0);
      end
    end
    check("t3_sum_lit", 32'(sum_out), -64);
    step("t3_after", 0, 0, 0);

    // Mixed signs hitting both extremes.
    for (int i = 0; i < N; i++) step("t4", 1, t4[i], 0);
    check("t4_sum_lit", 32'(sum_out), -1);
    check("t4_max_lit", 32'(max_out), 7);
    check("t4_min_lit", 32'(min_out), -8);

    // Back-to-back frames: strobes exactly N cycles apart.
    last_flag_cycle = -1;
    cycle = 0;
    for (int i = 0; i < 2 * N; i++) begin
      step("t5", 1, (i < N) ? 1 : -1, 0);
      if (sum_flag) begin
        if (last_flag_cycle >= 0) check("t5_spacing", 32'(cycle - last_flag_cycle), N);
        last_flag_cycle = cycle;
      end
      cycle++;
    end
    check("t5_sum_lit", 32'(sum_out), -8);
    check("t5_max_lit", 32'(max_out), -1);
    step("t5_after", 0, 0, 0);

    // clr without a sample discards the partial frame.
    for (int i = 0; i < 3; i++) step("t6", 1, 5, 0);
    step("t6_clr", 0, 0, 1);
    for (int i = 0; i < N; i++) step("t6", 1, 1, 0);
    check("t6_sum_lit", 32'(sum_out), 8);

    // Asynchronous reset pulse mid-frame.
    for (int i = 0; i < 3; i++) step("t6b", 1, 5, 0);
    @(negedge clk);
    din_flag = 1'b0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("t6b_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) step("t6b", 1, 1, 0);
    check("t6b_sum_lit", 32'(sum_out), 8);

    // clr together with a sample, including on the last-sample cycle.
    for (int i = 0; i < N - 1; i++) step("t7", 1, -3, 0);
    step("t7_clr_last", 1, 6, 1);
    for (int i = 0; i < N - 1; i++) step("t7", 1, 2, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)) - 8,
           1'($urandom_range(0, 24) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
